ripple4_down_timer: RTL and testbench

- Loadable down-counting timer. It is the counterpart of the team's 4-bit up-counting ripple counter.
- Counts from a programmed value down to zero and flags expiry with a one-cycle pulse. Optional auto-reload turns it into a periodic tick generator.
- Sits beside the up-counter in the counter library. Used as a timeout or interval generator by control logic that loads a count, starts it and waits for done.

---
 rtl/ripple4_down_timer.sv | 99 +++++++++
 tb/tb_ripple4_down_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ripple4_down_timer.sv
// Loadable down-counting timer with prescaler, one-cycle done pulse and
// optional auto-reload for periodic tick generation.
module ripple4_down_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] rld, rld_nx;
    logic [PW-1:0]    pcnt, pcnt_nx;
    logic             done_nx;
    logic             tick;

    assign tick = (state == RUN) && en && (pcnt == PMAX);

    // Next-state logic: load beats expiry/decrement, which beats start.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        rld_nx   = rld;
        pcnt_nx  = pcnt;
        done_nx  = 1'b0;
        if (load) begin
            // Abort anything in flight, including a tick on this edge.
            q_nx     = load_val;
            rld_nx   = load_val;
            state_nx = IDLE;
            pcnt_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt_nx = '0;
                    if (start) begin
                        if (q != '0) state_nx = RUN;
                        else         done_nx  = 1'b1;  // nothing to count
                    end
                end
                RUN: begin
                    if (tick) begin
                        pcnt_nx = '0;
                        if (q > WIDTH'(1)) begin
                            q_nx = q - WIDTH'(1);
                        end else begin
                            done_nx = 1'b1;
                            // A zero reload would leave RUN with q==0, so
                            // treat it as a one-shot instead.
                            if (auto_reload && (rld != '0)) begin
                                q_nx = rld;
                            end else begin
                                q_nx     = '0;
                                state_nx = IDLE;
                            end
                        end
                    end else if (en) begin
                        pcnt_nx = pcnt + PW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and datapath registers; busy and done are registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            pcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            rld   <= rld_nx;
            pcnt  <= pcnt_nx;
            busy  <= (state_nx == RUN);
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_ripple4_down_timer.sv
// Scoreboard bench: stimulus pushes expected (q,busy,done) per DUT, a
// monitor process pops and compares against the addressed DUT.
module tb_ripple4_down_timer;

    typedef struct {
        bit         id;     // 0 = PRESCALE 1 build, 1 = PRESCALE 4 build
        logic [3:0] q;
        logic       busy;
        logic       done;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event mon_ev;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_load = 0, a_start = 0, a_en = 1, a_ar = 0;
    logic [3:0] a_val = 0;
    logic       b_load = 0, b_start = 0, b_en = 1, b_ar = 0;
    logic [3:0] b_val = 0;
    logic [3:0] a_q, b_q;
    logic       a_busy, a_done, b_busy, b_done;

    always #5 clk = ~clk;

    ripple4_down_timer #(.WIDTH(4), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .load(a_load), .load_val(a_val),
        .start(a_start), .en(a_en), .auto_reload(a_ar),
        .q(a_q), .busy(a_busy), .done(a_done)
    );

    ripple4_down_timer #(.WIDTH(4), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .load(b_load), .load_val(b_val),
        .start(b_start), .en(b_en), .auto_reload(b_ar),
        .q(b_q), .busy(b_busy), .done(b_done)
    );

    // Monitor: drain the scoreboard shortly after each sample request.
    initial begin
        forever begin
            @(mon_ev);
            #1;
            while (sb.size() != 0) begin
                exp_t e;
                logic [3:0] q;
                logic       bz, dn;
                e  = sb.pop_front();
                q  = e.id ? b_q    : a_q;
                bz = e.id ? b_busy : a_busy;
                dn = e.id ? b_done : a_done;
                checks++;
                if (q !== e.q || bz !== e.busy || dn !== e.done) begin
                    errors++;
                    $display("FAIL %s: got q=%0d busy=%0b done=%0b, want q=%0d busy=%0b done=%0b",
                             e.nm, q, bz, dn, e.q, e.busy, e.done);
                end
            end
        end
    end

    task automatic push(input bit id, input int q, input bit bz, input bit dn, input string nm);
        exp_t e;
        e.id = id; e.q = 4'(q); e.busy = bz; e.done = dn; e.nm = nm;
        sb.push_back(e);
        ->mon_ev;
    endtask

    // Apply current inputs across one rising edge, then expect the result.
    task automatic edge_chk(input bit id, input int q, input bit bz, input bit dn, input string nm);
        @(posedge clk);
        push(id, q, bz, dn, nm);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset, then one-shot count from 5
        edge_chk(0, 0, 0, 0, "rst_e1");
        edge_chk(0, 0, 0, 0, "rst_e2");
        rst = 1'b1;
        a_load = 1; a_val = 5;
        edge_chk(0, 5, 0, 0, "load5");
        a_load = 0; a_start = 1;
        edge_chk(0, 5, 1, 0, "start5");
        a_start = 0;
        for (int i = 4; i >= 1; i--) edge_chk(0, i, 1, 0, "os_step");
        edge_chk(0, 0, 0, 1, "os_expire");
        edge_chk(0, 0, 0, 0, "os_done_clr");

        // 2. Auto-reload period of 3, then stop by clearing auto_reload
        a_load = 1; a_val = 3; a_ar = 1;
        edge_chk(0, 3, 0, 0, "ar_load");
        a_load = 0; a_start = 1;
        edge_chk(0, 3, 1, 0, "ar_start");
        a_start = 0;
        for (int r = 0; r < 2; r++) begin
            edge_chk(0, 2, 1, 0, "ar_q2");
            edge_chk(0, 1, 1, 0, "ar_q1");
            edge_chk(0, 3, 1, 1, "ar_reload");
        end
        edge_chk(0, 2, 1, 0, "ar_q2_last");
        edge_chk(0, 1, 1, 0, "ar_q1_last");
        a_ar = 0;
        edge_chk(0, 0, 0, 1, "ar_stop");
        edge_chk(0, 0, 0, 0, "ar_idle");

        // 4. Start ignored in RUN, load aborts on the tick edge
        a_load = 1; a_val = 2;
        edge_chk(0, 2, 0, 0, "ab_load2");
        a_load = 0; a_start = 1;
        edge_chk(0, 2, 1, 0, "ab_start");
        edge_chk(0, 1, 1, 0, "ab_start_ign");
        a_start = 0; a_load = 1; a_val = 9;
        edge_chk(0, 9, 0, 0, "ab_abort");
        a_load = 0;
        edge_chk(0, 9, 0, 0, "ab_no_done");

        // 5. Start with zero count expires immediately
        a_load = 1; a_val = 0;
        edge_chk(0, 0, 0, 0, "z_load0");
        a_load = 0; a_start = 1;
        edge_chk(0, 0, 0, 1, "z_start");
        a_start = 0;
        edge_chk(0, 0, 0, 0, "z_after");

        // 6. Asynchronous reset mid-run
        a_load = 1; a_val = 7;
        edge_chk(0, 7, 0, 0, "ar7_load");
        a_load = 0; a_start = 1;
        edge_chk(0, 7, 1, 0, "ar7_start");
        a_start = 0;
        rst = 1'b0;
        #1;
        push(0, 0, 0, 0, "async_rst_now");
        edge_chk(0, 0, 0, 0, "async_rst_hold");
        rst = 1'b1;
        edge_chk(0, 0, 0, 0, "post_rst1");
        edge_chk(0, 0, 0, 0, "post_rst2");

        // 3. Prescale 4 with an enable gap
        b_load = 1; b_val = 2;
        edge_chk(1, 2, 0, 0, "ps_load2");
        b_load = 0; b_start = 1;
        edge_chk(1, 2, 1, 0, "ps_start");
        b_start = 0;
        edge_chk(1, 2, 1, 0, "ps_e1");
        edge_chk(1, 2, 1, 0, "ps_e2");
        edge_chk(1, 2, 1, 0, "ps_e3");
        edge_chk(1, 1, 1, 0, "ps_tick1");
        edge_chk(1, 1, 1, 0, "ps_e5");
        edge_chk(1, 1, 1, 0, "ps_e6");
        b_en = 0;
        for (int i = 0; i < 6; i++) edge_chk(1, 1, 1, 0, "ps_frozen");
        b_en = 1;
        edge_chk(1, 1, 1, 0, "ps_e7");
        edge_chk(1, 0, 0, 1, "ps_expire");
        edge_chk(1, 0, 0, 0, "ps_idle");

        // Let the monitor finish; anything left over is a failure.
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
